// File: rtl/switch_cfg_reg_bank.sv
// Switch configuration register bank: applies config flits to the route LUT and
// dateline mask, and serves read-back requests over a valid/ready response channel.
module switch_cfg_reg_bank #(
   parameter int unsigned NUM_OUTPORTS = 5,
   parameter int unsigned TOTAL_NODES  = 32,
   parameter int unsigned TABLE_SIZE   = 32,
   parameter int unsigned ENTRY_W      = 16,
   parameter int unsigned FLIT_W       = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [FLIT_W-1:0]             cfg_flit,
   output logic                          reg_bank_claim,
   output logic [TABLE_SIZE*ENTRY_W-1:0] route_lut,
   output logic [NUM_OUTPORTS-1:0]       dateline,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [FLIT_W-1:0]             rsp_flit,
   output logic                          err
);

   localparam int unsigned IDX_W = 6;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COMMIT = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [ENTRY_W-1:0]      lut_q [TABLE_SIZE];
   logic [ENTRY_W-1:0]      lut_d [TABLE_SIZE];
   logic [NUM_OUTPORTS-1:0] dateline_q, dateline_d;
   logic [FLIT_W-1:0]       rsp_flit_q, rsp_flit_d;
   logic                    err_q, err_d;

   logic [1:0]              op_c;
   logic [IDX_W-1:0]        idx_c;
   logic                    accept_c;
   logic                    idx_ok_c;
   logic [ENTRY_W-1:0]      rd_entry_c;
   logic                    unused_c;

   assign op_c     = cfg_flit[31:30];
   assign idx_c    = cfg_flit[29:24];
   assign accept_c = cfg_valid && (state_q == S_IDLE);
   assign idx_ok_c = 32'(idx_c) < TABLE_SIZE;

   // Upper data bits and the fabric node count have no function inside the bank.
   assign unused_c = ^{cfg_flit[23:ENTRY_W], 32'(TOTAL_NODES)};

   always_comb begin
      rd_entry_c = '0;
      for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
         if (32'(idx_c) == i) rd_entry_c = lut_q[i];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               case (op_c)
                  2'b01, 2'b10: state_d = S_COMMIT;
                  2'b11:        state_d = S_RESP;
                  default:      state_d = S_IDLE;
               endcase
            end
         end
         S_COMMIT: state_d = S_IDLE;
         S_RESP:   if (rsp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      cfg_ready      = 1'b0;
      reg_bank_claim = 1'b0;
      rsp_valid      = 1'b0;
      cfg_ready      = (state_q == S_IDLE);
      reg_bank_claim = (state_q != S_IDLE);
      rsp_valid      = (state_q == S_RESP);
   end

   // Datapath updates happen only on the accept edge; out-of-range writes are dropped
   always_comb begin
      lut_d      = lut_q;
      dateline_d = dateline_q;
      rsp_flit_d = rsp_flit_q;
      err_d      = 1'b0;
      if (accept_c) begin
         case (op_c)
            2'b01: begin
               if (idx_ok_c) begin
                  for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
                     if (32'(idx_c) == i) lut_d[i] = cfg_flit[ENTRY_W-1:0];
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            2'b10: dateline_d = cfg_flit[NUM_OUTPORTS-1:0];
            2'b11: begin
               rsp_flit_d = {2'b11, idx_c, !idx_ok_c, 7'd0, 16'(rd_entry_c)};
               err_d      = !idx_ok_c;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < TABLE_SIZE; i++) lut_q[i] <= '0;
         dateline_q <= '0;
         rsp_flit_q <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < TABLE_SIZE; i++) lut_q[i] <= lut_d[i];
         dateline_q <= dateline_d;
         rsp_flit_q <= rsp_flit_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      route_lut = '0;
      for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
         route_lut[i*ENTRY_W +: ENTRY_W] = lut_q[i];
      end
   end

   assign dateline = dateline_q;
   assign rsp_flit = rsp_flit_q;
   assign err      = err_q;

endmodule
